// File: rtl/uart_rx_frame.sv
// UART frame receiver: 2-flop line synchroniser, mid-bit sampling at one of two
// baud divisors, optional even parity, one-cycle result strobe with error flags.
module uart_rx_frame #(
  parameter int CLKS_FAST = 46880,
  parameter int CLKS_SLOW = 93760,
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  input  logic                 baud_sel,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_SLOW);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] FAST_BIT  = CW'(CLKS_FAST - 1);
  localparam logic [CW-1:0] SLOW_BIT  = CW'(CLKS_SLOW - 1);
  // The IDLE detect clock is the first of the P/2 start-bit clocks, hence -2.
  localparam logic [CW-1:0] FAST_HALF = CW'(CLKS_FAST / 2 - 2);
  localparam logic [CW-1:0] SLOW_HALF = CW'(CLKS_SLOW / 2 - 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                 state;
  logic                   sync1;
  logic                   rx;
  logic [CW-1:0]          cnt;
  logic                   slow;
  logic [BW-1:0]          nbits;
  logic [DATA_BITS-1:0]   shift;
  logic                   perr;
  logic                   stop_bit;
  logic                   pend;
  logic [CW-1:0]          bit_last;
  logic [CW-1:0]          half_last;

  always_comb begin
    bit_last  = slow ? SLOW_BIT  : FAST_BIT;
    half_last = slow ? SLOW_HALF : FAST_HALF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= in;
      rx    <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      slow       <= 1'b0;
      nbits      <= '0;
      shift      <= '0;
      perr       <= 1'b0;
      stop_bit   <= 1'b1;
      pend       <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Stop sample raises pend; results publish one clock later.
      data_valid <= pend;
      pend       <= 1'b0;
      if (pend) begin
        data       <= shift;
        parity_err <= perr;
        frame_err  <= ~stop_bit;
      end

      case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            cnt   <= '0;
            slow  <= baud_sel;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == half_last) begin
            cnt   <= '0;
            nbits <= '0;
            perr  <= 1'b0;
            if (rx) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == bit_last) begin
            cnt   <= '0;
            shift <= {rx, shift[DATA_BITS-1:1]};
            if (nbits == BW'(DATA_BITS - 1)) begin
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              nbits <= nbits + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (cnt == bit_last) begin
            cnt   <= '0;
            perr  <= ^{shift, rx};
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == bit_last) begin
            cnt      <= '0;
            stop_bit <= rx;
            pend     <= 1'b1;
            if (rx) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rx) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and randomized frames for uart_rx_frame; expected results come from
// the frame bits and nominal bit timing, compared against an observed-strobe log.
module tb_uart_rx_frame;

  localparam int FAST = 16;
  localparam int SLOW = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic       baud_sel;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int cyc   = 0;
  int ncmp  = 0;
  int nfail = 0;

  int         o_cyc[$];
  logic [7:0] o_data[$];
  logic       o_pe[$];
  logic       o_fe[$];
  int         e_cyc[$];
  logic [7:0] e_data[$];
  logic       e_pe[$];
  logic       e_fe[$];

  uart_rx_frame #(
    .CLKS_FAST(FAST),
    .CLKS_SLOW(SLOW),
    .DATA_BITS(8),
    .PARITY_EN(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .baud_sel  (baud_sel),
    .data      (data),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      o_cyc.push_back(cyc);
      o_data.push_back(data);
      o_pe.push_back(parity_err);
      o_fe.push_back(frame_err);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame (start, data LSB first, parity, stop) and logs the expected strobe.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input logic sl, input logic tog);
    int p;
    logic [10:0] bits;
    p = sl ? SLOW : FAST;
    baud_sel = sl;
    bits = {stop, pbit, d, 1'b0};
    e_cyc.push_back(cyc + 2 + p / 2 + 10 * p + 1);
    e_data.push_back(d);
    e_pe.push_back(^{d, pbit});
    e_fe.push_back(~stop);
    for (int i = 0; i < 11; i++) begin
      in = bits[i];
      if (tog && i == 5) baud_sel = ~baud_sel;
      repeat (p) @(negedge clk);
    end
    baud_sel = sl;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && o_cyc.size() < e_cyc.size(); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({tag, ".count"}, o_cyc.size(), e_cyc.size());
    while (o_cyc.size() > 0 && e_cyc.size() > 0) begin
      check({tag, ".cyc"},  o_cyc.pop_front(),  e_cyc.pop_front());
      check({tag, ".data"}, o_data.pop_front(), e_data.pop_front());
      check({tag, ".perr"}, o_pe.pop_front(),   e_pe.pop_front());
      check({tag, ".ferr"}, o_fe.pop_front(),   e_fe.pop_front());
    end
    o_cyc.delete(); o_data.delete(); o_pe.delete(); o_fe.delete();
    e_cyc.delete(); e_data.delete(); e_pe.delete(); e_fe.delete();
  endtask

  initial begin
    logic [7:0] d0;
    logic       p0, f0, seen;
    logic [7:0] rd;
    logic       rp, rs, rl, rt;

    rst = 1'b1; in = 1'b1; baud_sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.data",  data, 0);
    check("rst.valid", data_valid, 0);
    check("rst.perr",  parity_err, 0);
    check("rst.ferr",  frame_err, 0);
    check("rst.busy",  busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("a5");
    repeat (10) @(negedge clk);

    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    drain("3c");
    repeat (10) @(negedge clk);

    // Reset in the middle of a frame.
    baud_sel = 1'b0;
    in = 1'b0;
    repeat (3 * FAST) @(negedge clk);
    check("mid.busy", busy, 1);
    rst = 1'b1; in = 1'b1;
    #1;
    check("mid.data",  data, 0);
    check("mid.valid", data_valid, 0);
    check("mid.perr",  parity_err, 0);
    check("mid.ferr",  frame_err, 0);
    check("mid.busy0", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30 * FAST) @(negedge clk);
    check("mid.nostrobe", o_cyc.size(), 0);
    check("mid.idle", busy, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("post_rst");

    // Stop bit low, line then held low for 100 bit times.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      repeat (FAST) @(negedge clk);
      check("brk.busy", busy, 1);
    end
    drain("brk");
    in = 1'b1;
    repeat (5) @(negedge clk);
    check("brk.release", busy, 0);
    check("brk.norepeat", o_cyc.size(), 0);

    // Short glitch on an idle line.
    repeat (10) @(negedge clk);
    d0 = data; p0 = parity_err; f0 = frame_err;
    in = 1'b0;
    repeat (4) @(negedge clk);
    in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 * FAST; i++) begin
      if (busy === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("gl.busy_pulse", seen, 1);
    repeat (20 * FAST) @(negedge clk);
    check("gl.busy", busy, 0);
    check("gl.nostrobe", o_cyc.size(), 0);
    check("gl.data", data, d0);
    check("gl.perr", parity_err, p0);
    check("gl.ferr", frame_err, f0);

    // Back-to-back frames, no idle gap.
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b1, 1'b0, 1'b0);
    in = 1'b1;
    drain("b2b");

    for (int n = 0; n < 8; n++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rl = 1'($urandom);
      rt = 1'($urandom);
      send_frame(rd, rp, rs, rl, rt);
      in = 1'b1;
      repeat (3 * SLOW) @(negedge clk);
      drain($sformatf("rnd%0d", n));
      check($sformatf("rnd%0d.idle", n), busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
